// File: rtl/data_loader_if.sv
// Loader-side bus: UART RX byte stream in, RAM write port and status flags out.
// The master modport is the UART/host side; the slave modport is the loader.
interface data_loader_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 8
);
  logic              start;
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic              wen;
  logic              busy;
  logic              fin;
  logic              ovr;
  logic [DATA_W-1:0] csum;

  modport master (
    output start, rx_valid, rx_data,
    input  addr, din, wen, busy, fin, ovr, csum
  );

  modport slave (
    input  start, rx_valid, rx_data,
    output addr, din, wen, busy, fin, ovr, csum
  );
endinterface

// File: rtl/data_loader.sv
// Writes received UART bytes into the image RAM at addresses 0..DEPTH-1, then flags fin.
// Optional running byte checksum on csum when LOADER_CHECKSUM_EN is defined.
module data_loader #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 262144
) (
  input logic         clk,
  input logic         rst,
  data_loader_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RECEIVE, WRITE, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] din_reg, din_next;
  logic              wen_reg, wen_next;
  logic              fin_reg, fin_next;
  logic              ovr_reg, ovr_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      din_reg   <= '0;
      wen_reg   <= 1'b0;
      fin_reg   <= 1'b0;
      ovr_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      din_reg   <= din_next;
      wen_reg   <= wen_next;
      fin_reg   <= fin_next;
      ovr_reg   <= ovr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    din_next   = din_reg;
    wen_next   = 1'b0;
    fin_next   = fin_reg;
    ovr_next   = ovr_reg;
    case (state_reg)
      IDLE: begin
        addr_next = '0;
        if (!bus.start) begin
          fin_next   = 1'b0;
          ovr_next   = 1'b0;
          state_next = RECEIVE;
        end
      end
      RECEIVE: begin
        if (bus.rx_valid) begin
          din_next   = bus.rx_data;
          wen_next   = 1'b1;
          state_next = WRITE;
        end
      end
      WRITE: begin
        // A byte landing here cannot be stored; drop it and remember the loss.
        if (bus.rx_valid) ovr_next = 1'b1;
        if (addr_reg == LAST_ADDR) begin
          fin_next   = 1'b1;
          state_next = DONE;
        end else begin
          addr_next  = addr_reg + 1'b1;
          state_next = RECEIVE;
        end
      end
      DONE: begin
        if (bus.start) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.addr = addr_reg;
  assign bus.din  = din_reg;
  assign bus.wen  = wen_reg;
  assign bus.fin  = fin_reg;
  assign bus.ovr  = ovr_reg;
  assign bus.busy = (state_reg == RECEIVE) || (state_reg == WRITE);

`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] csum_reg, csum_next;

  always_ff @(posedge clk) begin
    if (rst) csum_reg <= '0;
    else     csum_reg <= csum_next;
  end

  // Accumulate on the same cycle the byte is latched for writing.
  always_comb begin
    csum_next = csum_reg;
    if (state_reg == IDLE && !bus.start)
      csum_next = '0;
    else if (state_reg == RECEIVE && bus.rx_valid)
      csum_next = csum_reg + bus.rx_data;
  end

  assign bus.csum = csum_reg;
`else
  assign bus.csum = '0;
`endif

endmodule

// File: tb/tb_data_loader.sv
// Randomized self-checking bench for data_loader with DEPTH=4.
module tb_data_loader;

  localparam int ADDR_W = 18;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  logic [ADDR_W-1:0] log_addr[$];
  logic [DATA_W-1:0] log_data[$];

  data_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  data_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Record every RAM write as the RAM would see it at the clock edge.
  always @(posedge clk) begin
    if (bus.wen === 1'b1) begin
      log_addr.push_back(bus.addr);
      log_data.push_back(bus.din);
    end
  end

  // Reference checksum: plain byte sum mod 256, or 0 when the feature is absent.
  function automatic logic [DATA_W-1:0] model_csum(input logic [DATA_W-1:0] q[$]);
    int s = 0;
    foreach (q[i]) s += int'(q[i]);
`ifdef LOADER_CHECKSUM_EN
    return DATA_W'(s % 256);
`else
    return '0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_byte(input logic [DATA_W-1:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic go_idle();
    bus.start    = 1'b1;
    bus.rx_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic send_all(input logic [DATA_W-1:0] q[$]);
    foreach (q[i]) begin
      pulse_byte(q[i]);
      tick();
      repeat ($urandom_range(0, 3)) tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      bus.start    = 1'($urandom);
      bus.rx_valid = 1'($urandom);
      bus.rx_data  = 8'($urandom);
      tick();
      tests++;
      if ({bus.addr, bus.din, bus.wen, bus.busy, bus.fin, bus.ovr, bus.csum} !== '0) begin
        fails++;
        $display("FAIL reset_outputs cycle %0d: addr=%h din=%h wen=%b busy=%b fin=%b ovr=%b csum=%h, required all 0",
                 c, bus.addr, bus.din, bus.wen, bus.busy, bus.fin, bus.ovr, bus.csum);
      end
    end
    tests++;
    if (log_addr.size() != 0) begin
      fails++;
      $display("FAIL reset_no_wen: %0d writes seen, required 0", log_addr.size());
    end
    $display("[TB] reset: 3 cycles checked");
    bus.start = 1'b1; bus.rx_valid = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_load_fixed();
    logic [DATA_W-1:0] q[$] = '{8'hA5, 8'h3C, 8'hFF, 8'h01};
    go_idle();
    log_addr.delete(); log_data.delete();
    bus.start = 1'b0;
    tick();
    tests++;
    if (bus.busy !== 1'b1) begin
      fails++; $display("FAIL load_busy: busy=%b required 1", bus.busy);
    end
    for (int i = 0; i < DEPTH; i++) begin
      pulse_byte(q[i]);
      tests++;
      if (bus.wen !== 1'b1 || bus.addr !== ADDR_W'(i) || bus.din !== q[i]) begin
        fails++;
        $display("FAIL load_write %0d: wen=%b addr=%0d din=%h, required wen=1 addr=%0d din=%h",
                 i, bus.wen, bus.addr, bus.din, i, q[i]);
      end
      tick();
      tests++;
      if (bus.wen !== 1'b0 || bus.fin !== (i == DEPTH - 1)) begin
        fails++;
        $display("FAIL load_after_write %0d: wen=%b fin=%b, required wen=0 fin=%b",
                 i, bus.wen, bus.fin, i == DEPTH - 1);
      end
      $display("[TB] load_fixed: byte %0d = %h", i, q[i]);
      if (i < DEPTH - 1) repeat ($urandom_range(0, 3)) tick();
    end
    tests++;
    if (bus.csum !== model_csum(q)) begin
      fails++; $display("FAIL load_csum: csum=%h required %h", bus.csum, model_csum(q));
    end
    repeat (3) tick();
    tests++;
    if (bus.fin !== 1'b1 || bus.addr !== ADDR_W'(DEPTH - 1) || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL done_hold: fin=%b addr=%0d busy=%b, required fin=1 addr=%0d busy=0",
               bus.fin, bus.addr, bus.busy, DEPTH - 1);
    end
    bus.start = 1'b1;
    tick();
    tests++;
    if (bus.fin !== 1'b1 || bus.busy !== 1'b0) begin
      fails++; $display("FAIL release_fin: fin=%b busy=%b, required fin=1 busy=0", bus.fin, bus.busy);
    end
    bus.start = 1'b0;
    tick();
    tests++;
    if (bus.fin !== 1'b0 || bus.busy !== 1'b1) begin
      fails++; $display("FAIL restart_fin: fin=%b busy=%b, required fin=0 busy=1", bus.fin, bus.busy);
    end
  endtask

  task automatic test_random_loads();
    for (int it = 0; it < 3; it++) begin
      logic [DATA_W-1:0] q[$];
      int bad = 0;
      go_idle();
      log_addr.delete(); log_data.delete();
      for (int i = 0; i < DEPTH; i++) q.push_back(8'($urandom));
      bus.start = 1'b0;
      tick();
      send_all(q);
      for (int i = 0; i < DEPTH; i++)
        if (i >= log_addr.size() || log_addr[i] !== ADDR_W'(i) || log_data[i] !== q[i]) bad++;
      tests++;
      if (bad != 0 || log_addr.size() != DEPTH) begin
        fails++;
        $display("FAIL random_image %0d: %0d writes, %0d wrong, required %0d correct", it, log_addr.size(), bad, DEPTH);
      end
      tests++;
      if (bus.fin !== 1'b1 || bus.csum !== model_csum(q)) begin
        fails++;
        $display("FAIL random_fin %0d: fin=%b csum=%h, required fin=1 csum=%h", it, bus.fin, bus.csum, model_csum(q));
      end
      $display("[TB] random_load %0d: %h %h %h %h", it, q[0], q[1], q[2], q[3]);
    end
  endtask

  task automatic test_overrun();
    logic [DATA_W-1:0] rest[$];
    logic [DATA_W-1:0] expq[$];
    int bad = 0;
    go_idle();
    log_addr.delete(); log_data.delete();
    rest.push_back(8'($urandom));
    rest.push_back(8'($urandom));
    expq = '{8'h11, 8'h33, rest[0], rest[1]};
    bus.start = 1'b0;
    tick();
    pulse_byte(8'h11);
    pulse_byte(8'h22);
    tests++;
    if (bus.ovr !== 1'b1) begin
      fails++; $display("FAIL overrun_flag: ovr=%b required 1", bus.ovr);
    end
    tick();
    pulse_byte(8'h33);
    tick();
    send_all(rest);
    for (int i = 0; i < DEPTH; i++)
      if (i >= log_addr.size() || log_addr[i] !== ADDR_W'(i) || log_data[i] !== expq[i]) bad++;
    tests++;
    if (bad != 0 || log_addr.size() != DEPTH) begin
      fails++;
      $display("FAIL overrun_image: %0d writes, %0d wrong, required 11,33,%h,%h at 0..3", log_addr.size(), bad, rest[0], rest[1]);
    end
    tests++;
    if (bus.ovr !== 1'b1 || bus.fin !== 1'b1) begin
      fails++; $display("FAIL overrun_sticky: ovr=%b fin=%b, required 1 1", bus.ovr, bus.fin);
    end
    $display("[TB] overrun: 22 dropped, image 11 33 %h %h", rest[0], rest[1]);
    bus.start = 1'b1; tick();
    bus.start = 1'b0; tick();
    tests++;
    if (bus.ovr !== 1'b0) begin
      fails++; $display("FAIL overrun_clear: ovr=%b required 0 after start", bus.ovr);
    end
  endtask

  task automatic test_reset_mid();
    logic [DATA_W-1:0] q[$];
    int bad = 0;
    go_idle();
    bus.start = 1'b0;
    tick();
    pulse_byte(8'($urandom)); tick();
    pulse_byte(8'($urandom)); tick();
    rst = 1'b1;
    tick();
    tests++;
    if ({bus.addr, bus.din, bus.wen, bus.busy, bus.fin, bus.ovr, bus.csum} !== '0) begin
      fails++;
      $display("FAIL midreset_outputs: addr=%h din=%h wen=%b busy=%b fin=%b ovr=%b csum=%h, required all 0",
               bus.addr, bus.din, bus.wen, bus.busy, bus.fin, bus.ovr, bus.csum);
    end
    rst = 1'b0;
    tick();
    log_addr.delete(); log_data.delete();
    for (int i = 0; i < DEPTH; i++) q.push_back(8'($urandom));
    send_all(q);
    for (int i = 0; i < DEPTH; i++)
      if (i >= log_addr.size() || log_addr[i] !== ADDR_W'(i) || log_data[i] !== q[i]) bad++;
    tests++;
    if (bad != 0 || log_addr.size() != DEPTH || bus.fin !== 1'b1) begin
      fails++;
      $display("FAIL midreset_reload: %0d writes, %0d wrong, fin=%b, required %0d correct and fin=1", log_addr.size(), bad, bus.fin, DEPTH);
    end
    $display("[TB] reset_mid: reload of %0d bytes", DEPTH);
  endtask

  task automatic test_checksum();
    logic [DATA_W-1:0] q[$] = '{8'h80, 8'h80, 8'h10, 8'h05};
    logic [DATA_W-1:0] req;
`ifdef LOADER_CHECKSUM_EN
    req = 8'h15;
`else
    req = 8'h00;
`endif
    go_idle();
    bus.start = 1'b0;
    tick();
    send_all(q);
    tests++;
    if (bus.fin !== 1'b1 || bus.csum !== req) begin
      fails++; $display("FAIL checksum: fin=%b csum=%h, required fin=1 csum=%h", bus.fin, bus.csum, req);
    end
    tests++;
    if (bus.csum !== model_csum(q)) begin
      fails++; $display("FAIL checksum_model: csum=%h model %h", bus.csum, model_csum(q));
    end
    $display("[TB] checksum: csum=%h", bus.csum);
  endtask

  task automatic test_ignore();
    go_idle();
    bus.start = 1'b0;
    tick();
    pulse_byte(8'($urandom));
    pulse_byte(8'($urandom));
    tick();
    send_all('{8'($urandom), 8'($urandom), 8'($urandom)});
    log_addr.delete(); log_data.delete();
    for (int i = 0; i < 3; i++) begin pulse_byte(8'($urandom)); tick(); end
    tests++;
    if (log_addr.size() != 0 || bus.addr !== ADDR_W'(DEPTH - 1) || bus.fin !== 1'b1 || bus.ovr !== 1'b1) begin
      fails++;
      $display("FAIL done_ignore: writes=%0d addr=%0d fin=%b ovr=%b, required 0 %0d 1 1",
               log_addr.size(), bus.addr, bus.fin, bus.ovr, DEPTH - 1);
    end
    bus.start = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin pulse_byte(8'($urandom)); tick(); end
    tests++;
    if (log_addr.size() != 0 || bus.addr !== '0 || bus.fin !== 1'b1 || bus.ovr !== 1'b1 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_ignore: writes=%0d addr=%0d fin=%b ovr=%b busy=%b, required 0 0 1 1 0",
               log_addr.size(), bus.addr, bus.fin, bus.ovr, bus.busy);
    end
    $display("[TB] ignore: rx_valid in DONE and IDLE produced %0d writes", log_addr.size());
  endtask

  initial begin
    bus.start    = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    test_reset();
    test_load_fixed();
    test_random_loads();
    test_overrun();
    test_reset_mid();
    test_checksum();
    test_ignore();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
